// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
// The CSUM state exists only when UART_CMD_CKSUM_EN is defined.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
`ifdef UART_CMD_CKSUM_EN
    ST_CSUM,
`endif
    ST_DRAIN
  } state_t;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  function automatic int idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_buf.sv
// Payload buffer: single clock, synchronous write port, combinational read port.
module uart_cmd_buf #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic [IW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame assembler behind the UART receiver: HEADER, ADDR, LEN, payload[, CSUM],
// replayed onto a ready/valid register-write port. Checksum stage: UART_CMD_CKSUM_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT,
  parameter int         TIMEOUT = 104_160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_rdy,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int            IW        = idx_w(MAX_LEN);
  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_TERM    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx, tcnt_inc;
  logic [IW-1:0] idx, idx_nx, last, last_nx, rd_idx;
  logic [7:0]    base, base_nx, rd_data;
  logic          ok_pend, ok_pend_nx;
  logic          wr_en_nx, busy_nx, frame_ok_nx, frame_err_nx;
  logic [7:0]    wr_addr_nx, wr_data_nx;
  logic [1:0]    err_code_nx;
  logic          timed, buf_we;
`ifdef UART_CMD_CKSUM_EN
  logic [7:0]    csum, csum_nx;
`endif

  uart_cmd_buf #(.DEPTH(MAX_LEN), .IW(IW)) u_buf (
    .clk (clk),
    .we  (buf_we),
    .wa  (idx),
    .wd  (rx_data),
    .ra  (rd_idx),
    .rd  (rd_data)
  );

  assign buf_we   = rx_vld && (state == ST_DATA);
  assign tcnt_inc = tcnt + TW'(1);
`ifdef UART_CMD_CKSUM_EN
  assign timed = state inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM};
`else
  assign timed = state inside {ST_ADDR, ST_LEN, ST_DATA};
`endif

  always_comb begin
    state_nx     = state;
    tcnt_nx      = '0;
    idx_nx       = idx;
    last_nx      = last;
    base_nx      = base;
    ok_pend_nx   = 1'b0;
    wr_en_nx     = wr_en;
    wr_addr_nx   = wr_addr;
    wr_data_nx   = wr_data;
    frame_ok_nx  = 1'b0;
    frame_err_nx = 1'b0;
    err_code_nx  = err_code;
    rd_idx       = idx + IW'(1);
`ifdef UART_CMD_CKSUM_EN
    csum_nx      = csum;
`endif
    if (timed) tcnt_nx = rx_vld ? '0 : tcnt_inc;

    case (state)
      ST_IDLE: begin
        // A completion deferred behind an overrun error is reported here.
        frame_ok_nx = ok_pend;
`ifdef UART_CMD_CKSUM_EN
        csum_nx = '0;
`endif
        if (rx_vld && rx_data == HEADER) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        if (rx_vld) begin
          base_nx  = rx_data;
`ifdef UART_CMD_CKSUM_EN
          csum_nx  = rx_data;
`endif
          state_nx = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_vld) begin
          if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
            last_nx  = IW'(rx_data - 8'd1);
            idx_nx   = '0;
`ifdef UART_CMD_CKSUM_EN
            csum_nx  = csum + rx_data;
`endif
            state_nx = ST_DATA;
          end else begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_LEN;
            state_nx     = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        rd_idx = '0;
        if (rx_vld) begin
          idx_nx = idx + IW'(1);
`ifdef UART_CMD_CKSUM_EN
          csum_nx = csum + rx_data;
          if (idx == last) state_nx = ST_CSUM;
`else
          if (idx == last) begin
            state_nx   = ST_DRAIN;
            idx_nx     = '0;
            wr_en_nx   = 1'b1;
            wr_addr_nx = base;
            // With a single-byte payload, byte 0 is still in flight to the buffer.
            wr_data_nx = (idx == '0) ? rx_data : rd_data;
          end
`endif
        end
      end
`ifdef UART_CMD_CKSUM_EN
      ST_CSUM: begin
        rd_idx = '0;
        if (rx_vld) begin
          if (rx_data == csum) begin
            state_nx   = ST_DRAIN;
            idx_nx     = '0;
            wr_en_nx   = 1'b1;
            wr_addr_nx = base;
            wr_data_nx = rd_data;
          end else begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_CSUM;
            state_nx     = ST_IDLE;
          end
        end
      end
`endif
      ST_DRAIN: begin
        if (rx_vld) begin
          frame_err_nx = 1'b1;
          err_code_nx  = ERR_OVERRUN;
        end
        if (wr_en && wr_rdy) begin
          if (idx == last) begin
            wr_en_nx    = 1'b0;
            state_nx    = ST_IDLE;
            idx_nx      = '0;
            ok_pend_nx  = rx_vld;
            frame_ok_nx = !rx_vld;
          end else begin
            idx_nx     = rd_idx;
            wr_addr_nx = wr_addr + 8'd1;
            wr_data_nx = rd_data;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (timed && !rx_vld && tcnt_inc == T_TERM) begin
      frame_err_nx = 1'b1;
      err_code_nx  = ERR_TIMEOUT;
      state_nx     = ST_IDLE;
      tcnt_nx      = '0;
    end

    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      idx       <= '0;
      ok_pend   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      idx       <= idx_nx;
      ok_pend   <= ok_pend_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
      wr_data   <= wr_data_nx;
      busy      <= busy_nx;
      frame_ok  <= frame_ok_nx;
      frame_err <= frame_err_nx;
      err_code  <= err_code_nx;
    end
  end

  always_ff @(posedge clk) begin
    base <= base_nx;
    last <= last_nx;
`ifdef UART_CMD_CKSUM_EN
    csum <= csum_nx;
`endif
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed vector table, hand-written corner sequences,
// and randomized frames against a list-based frame model.
module tb_uart_cmd_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 40;
  localparam logic [7:0] HDR     = 8'hA5;
`ifdef UART_CMD_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, rx_vld, wr_rdy, wr_en, busy, frame_ok, frame_err;
  logic [7:0] rx_data, wr_addr, wr_data;
  logic [1:0] err_code;

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .HEADER(HDR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_vld(rx_vld), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, vld_cyc = 0, ok_cyc = 0, err_cyc = 0;
  int obs_ok = 0, stall_viol = 0, coincide = 0, hold_cnt = 0;
  logic [15:0] obs_wr[$];
  int          obs_err[$];
  logic [15:0] exp_wr[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_a = 8'h0, prev_d = 8'h0;
  int rdy_mode = 0;
  int wb, ob, eb;

  // Monitor: everything observed at the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_vld) vld_cyc <= cyc;
    if (wr_en && wr_rdy) obs_wr.push_back({wr_addr, wr_data});
    if (frame_ok) begin obs_ok <= obs_ok + 1; ok_cyc <= cyc; end
    if (frame_err) begin obs_err.push_back(int'(err_code)); err_cyc <= cyc; end
    if (frame_ok && frame_err) coincide <= coincide + 1;
    if (prev_stall && (!wr_en || wr_addr != prev_a || wr_data != prev_d)) stall_viol <= stall_viol + 1;
    if (wr_en && wr_addr == 8'h10 && wr_data == 8'h11) hold_cnt <= hold_cnt + 1;
    prev_stall <= wr_en && !wr_rdy;
    prev_a     <= wr_addr;
    prev_d     <= wr_data;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_mode == 0) wr_rdy = 1'b1;
    else if (rdy_mode == 1) wr_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_vld = 1'b1; rx_data = b;
    tick();
    rx_vld = 1'b0; rx_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] lb, input logic [7:0] pl[$],
                            input logic [7:0] ck, input int gap);
    bit ok_len;
    ok_len = (lb >= 1 && lb <= MAX_LEN);
    send_byte(HDR, gap);
    send_byte(a, gap);
    send_byte(lb, ok_len ? gap : 0);
    if (ok_len) begin
      for (int i = 0; i < pl.size(); i++) send_byte(pl[i], (i == pl.size() - 1 && !CK) ? 0 : gap);
      if (CK) send_byte(ck, 0);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 4000) begin tick(); n++; end
    chk({nm, " idle_bound"}, int'(busy), 0);
    repeat (3) tick();
  endtask

  task automatic snap();
    wb = obs_wr.size(); ob = obs_ok; eb = obs_err.size();
  endtask

  task automatic chk_frame(input string nm, input int exp_err, input int exp_ok);
    chk({nm, " nwr"}, obs_wr.size() - wb, exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (wb + i < obs_wr.size()) chk({nm, " write"}, int'(obs_wr[wb + i]), int'(exp_wr[i]));
    chk({nm, " ok_cnt"}, obs_ok - ob, exp_ok);
    chk({nm, " err_cnt"}, obs_err.size() - eb, (exp_err >= 0) ? 1 : 0);
    if (exp_err >= 0 && obs_err.size() > eb) chk({nm, " err_code"}, obs_err[eb], exp_err);
  endtask

  // Frame outcome from the framing rules: -1 accepted, else abort code.
  function automatic int model_frame(input logic [7:0] a, input logic [7:0] lb,
                                     input logic [7:0] pl[$], input logic [7:0] ck);
    int s;
    exp_wr.delete();
    if (lb == 0 || lb > MAX_LEN) return 0;
    s = a + lb;
    foreach (pl[i]) s += pl[i];
    if (CK && (s % 256) != ck) return 1;
    for (int i = 0; i < lb; i++) exp_wr.push_back({8'((a + i) % 256), pl[i]});
    return -1;
  endfunction

  typedef struct {
    logic [7:0] addr; logic [7:0] lenb; logic [7:0] p0; logic [7:0] p1; logic [7:0] ck;
    int err_ck; int err_nk;
    logic [7:0] fa; logic [7:0] fd; logic [7:0] la; logic [7:0] ld;
  } vec_t;

  vec_t vt[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int         e;

    vt[0] = '{8'h10, 8'h02, 8'h11, 8'h22, 8'h45, -1, -1, 8'h10, 8'h11, 8'h11, 8'h22};
    vt[1] = '{8'hFF, 8'h02, 8'h01, 8'h02, 8'h04, -1, -1, 8'hFF, 8'h01, 8'h00, 8'h02};
    vt[2] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00,  0,  0, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3] = '{8'h10, 8'h11, 8'h00, 8'h00, 8'h00,  0,  0, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[4] = '{8'h10, 8'h01, 8'h33, 8'h00, 8'h00,  1, -1, 8'h10, 8'h33, 8'h10, 8'h33};
    vt[5] = '{8'h80, 8'h01, 8'h7F, 8'h00, 8'h00, -1, -1, 8'h80, 8'h7F, 8'h80, 8'h7F};

    rst = 1'b1; rx_vld = 1'b0; rx_data = 8'h00; wr_rdy = 1'b1;
    tick(); tick();
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst frame_ok", int'(frame_ok), 0);
    chk("rst frame_err", int'(frame_err), 0);
    chk("rst err_code", int'(err_code), 0);
    rst = 1'b0;
    tick();

    // Directed vectors, sink always ready.
    for (int v = 0; v < 6; v++) begin
      q.delete();
      if (vt[v].lenb >= 1) q.push_back(vt[v].p0);
      if (vt[v].lenb == 2) q.push_back(vt[v].p1);
      e = CK ? vt[v].err_ck : vt[v].err_nk;
      exp_wr.delete();
      if (e < 0) begin
        exp_wr.push_back({vt[v].fa, vt[v].fd});
        if (vt[v].lenb == 2) exp_wr.push_back({vt[v].la, vt[v].ld});
      end
      snap();
      send_frame(vt[v].addr, vt[v].lenb, q, vt[v].ck, 0);
      wait_idle("vec");
      chk_frame("vec", e, (e < 0) ? 1 : 0);
      if (e < 0) chk("vec latency", ok_cyc - vld_cyc, int'(vt[v].lenb) + 1);
    end

    // Sink stalls three cycles on the first write.
    q = {8'h11, 8'h22};
    e = model_frame(8'h10, 8'h02, q, 8'h45);
    rdy_mode = 2; wr_rdy = 1'b0;
    snap(); hold_cnt = hold_cnt;
    begin
      int hb;
      hb = hold_cnt;
      send_frame(8'h10, 8'h02, q, 8'h45, 0);
      repeat (3) tick();
      wr_rdy = 1'b1; rdy_mode = 0;
      wait_idle("stall");
      chk("stall hold_cycles", hold_cnt - hb, 4);
    end
    chk_frame("stall", e, 1);

    // Silence after ADDR: timeout abort, then a clean frame.
    snap();
    send_byte(HDR, 0);
    send_byte(8'h10, 0);
    begin
      int n = 0;
      while (obs_err.size() == eb && n < TIMEOUT + 20) begin tick(); n++; end
    end
    exp_wr.delete();
    chk_frame("timeout", 2, 0);
    chk("timeout latency", err_cyc - vld_cyc, TIMEOUT);
    q = {8'h01, 8'h02};
    e = model_frame(8'hFF, 8'h02, q, 8'h04);
    snap();
    send_frame(8'hFF, 8'h02, q, 8'h04, 0);
    wait_idle("after_to");
    chk_frame("after_to", e, 1);

    // Stray byte while the sink is stalled in the drain.
    q = {8'h11, 8'h22};
    e = model_frame(8'h10, 8'h02, q, 8'h45);
    rdy_mode = 2; wr_rdy = 1'b0;
    snap();
    send_frame(8'h10, 8'h02, q, 8'h45, 0);
    send_byte(8'h55, 0);
    wr_rdy = 1'b1; rdy_mode = 0;
    wait_idle("overrun");
    chk_frame("overrun", 3, 1);

    // Stray byte on the same edge as the final accepted write.
    snap();
    send_frame(8'h10, 8'h02, q, 8'h45, 0);
    tick();
    send_byte(8'h55, 0);
    wait_idle("ovr_last");
    chk_frame("ovr_last", 3, 1);
    chk("ovr_last ok_after_err", ok_cyc - err_cyc, 1);

    // Reset in the middle of the payload.
    snap();
    send_byte(HDR, 0); send_byte(8'h10, 0); send_byte(8'h04, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    chk("rst_mid busy_before", int'(busy), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid busy_after", int'(busy), 0);
    repeat (5) tick();
    exp_wr.delete();
    chk_frame("rst_mid", -1, 0);
    q = {8'h7F};
    e = model_frame(8'h80, 8'h01, q, 8'h00);
    snap();
    send_frame(8'h80, 8'h01, q, 8'h00, 0);
    wait_idle("after_rst");
    chk_frame("after_rst", e, 1);

    // Randomized frames with a randomly stalling sink.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      logic [7:0] a, lb, ck, g;
      int s, gap, ng;
      a = 8'($urandom);
      if ($urandom_range(0, 9) == 0)
        lb = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
      else
        lb = 8'($urandom_range(1, MAX_LEN));
      q.delete();
      if (lb >= 1 && lb <= MAX_LEN) for (int i = 0; i < lb; i++) q.push_back(8'($urandom));
      s = a + lb;
      foreach (q[i]) s += q[i];
      ck = 8'(s);
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'h5A;
      e = model_frame(a, lb, q, ck);
      gap = $urandom_range(0, 3);
      ng = $urandom_range(0, 2);
      snap();
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'h00;
        send_byte(g, 0);
      end
      send_frame(a, lb, q, ck, gap);
      wait_idle("rand");
      chk_frame("rand", e, (e < 0) ? 1 : 0);
    end
    rdy_mode = 0;
    tick();

    chk("hold_stable", stall_viol, 0);
    chk("no_coincide", coincide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
